// File: rtl/z80_bus_arbiter_if.sv
// z80_bus_arbiter_if: request/grant lines between the Z80 bus arbiter,
// the external bus masters and the T80 core's BUSRQ_n/BUSAK_n pair.
// The arbiter connects through the master modport; the masters and the
// core model connect through the slave modport.
interface z80_bus_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0] REQ;
    logic [N_REQ-1:0] GNT;
    logic [N_REQ-1:0] REVOKED;
    logic             BUSRQ_n;
    logic             BUSAK_n;
    logic             BUS_OWNED;

    modport master (
        input  REQ,
        input  BUSAK_n,
        output GNT,
        output BUSRQ_n,
        output BUS_OWNED,
        output REVOKED
    );

    modport slave (
        output REQ,
        output BUSAK_n,
        input  GNT,
        input  BUSRQ_n,
        input  BUS_OWNED,
        input  REVOKED
    );
endinterface

// File: rtl/z80_bus_arbiter.sv
// z80_bus_arbiter: shares the Z80 external bus between the T80 core and
// N_REQ bus masters. Requests BUSRQ_n from the core, waits for BUSAK_n,
// then grants one master at a time in round-robin order. Every grant is
// followed by a CPU window of CPU_GAP cycles so the core keeps running.
// Optional feature: define Z80_BUS_ARB_TIMEOUT_EN to revoke grants held
// longer than HOLD_MAX cycles and mask the offender until it drops REQ.
module z80_bus_arbiter #(
    parameter int N_REQ    = 2,
    parameter int CPU_GAP  = 4,
    parameter int HOLD_MAX = 64
) (
    input  logic               CLK_n,
    input  logic               RESET,
    z80_bus_arbiter_if.master  bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Reject parameter values outside the supported ranges at elaboration.
    if (N_REQ < 1 || N_REQ > 8) begin : g_bad_n_req
        $error("z80_bus_arbiter: N_REQ must be 1..8");
    end
    if (CPU_GAP < 1 || CPU_GAP > 255) begin : g_bad_cpu_gap
        $error("z80_bus_arbiter: CPU_GAP must be 1..255");
    end
    if (HOLD_MAX < 1 || HOLD_MAX > 65535) begin : g_bad_hold_max
        $error("z80_bus_arbiter: HOLD_MAX must be 1..65535");
    end

    typedef enum logic [2:0] {
        IDLE,
        ACQUIRE,
        GRANT,
        RELEASE,
        GAP
    } state_t;

    state_t           state, state_nxt;
    logic [N_REQ-1:0] gnt, gnt_nxt;
    logic             busrq_n, busrq_n_nxt;
    logic [IDX_W-1:0] last_gnt, last_gnt_nxt;
    logic [IDX_W-1:0] winner, winner_nxt;
    logic [7:0]       gap_cnt, gap_cnt_nxt;
    logic [IDX_W-1:0] rr_pick;
    logic             rr_found;
    logic [N_REQ-1:0] elig_req;
    logic [N_REQ-1:0] winner_oh;
    logic             winner_req;

`ifdef Z80_BUS_ARB_TIMEOUT_EN
    logic [15:0]      hold_cnt, hold_cnt_nxt;
    logic [N_REQ-1:0] mask, mask_nxt;
    logic [N_REQ-1:0] revoked, revoked_nxt;

    assign elig_req = bus.REQ & ~mask;
`else
    assign elig_req = bus.REQ;
`endif

    assign winner_oh  = N_REQ'(1) << winner;
    assign winner_req = bus.REQ[winner];

    // Round-robin search: first eligible requester above last_gnt, wrapping.
    always_comb begin : rr_select
        int unsigned      sum;
        logic [IDX_W-1:0] cand;
        rr_found = 1'b0;
        rr_pick  = '0;
        sum      = 0;
        cand     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum  = (int'(last_gnt) + k) % N_REQ;
            cand = IDX_W'(sum);
            if (!rr_found && elig_req[cand]) begin
                rr_found = 1'b1;
                rr_pick  = cand;
            end
        end
    end

    // Next-state and next-output logic for the bus handover sequence.
    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        busrq_n_nxt  = busrq_n;
        last_gnt_nxt = last_gnt;
        winner_nxt   = winner;
        gap_cnt_nxt  = gap_cnt;
`ifdef Z80_BUS_ARB_TIMEOUT_EN
        hold_cnt_nxt = '0;
        revoked_nxt  = '0;
        mask_nxt     = mask & bus.REQ;
`endif
        case (state)
            IDLE: begin
                busrq_n_nxt = 1'b1;
                if (rr_found && gap_cnt == 8'd0) begin
                    winner_nxt  = rr_pick;
                    busrq_n_nxt = 1'b0;
                    state_nxt   = ACQUIRE;
                end
            end
            ACQUIRE: begin
                busrq_n_nxt = 1'b0;
                if (!winner_req) begin
                    busrq_n_nxt = 1'b1;
                    state_nxt   = RELEASE;
                end else if (!bus.BUSAK_n) begin
                    gnt_nxt   = winner_oh;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                busrq_n_nxt = 1'b0;
`ifdef Z80_BUS_ARB_TIMEOUT_EN
                hold_cnt_nxt = (hold_cnt == 16'hFFFF) ? hold_cnt : hold_cnt + 16'd1;
`endif
                if (!winner_req || bus.BUSAK_n) begin
                    gnt_nxt      = '0;
                    busrq_n_nxt  = 1'b1;
                    last_gnt_nxt = winner;
                    state_nxt    = RELEASE;
                end
`ifdef Z80_BUS_ARB_TIMEOUT_EN
                else if (hold_cnt == 16'(HOLD_MAX - 1)) begin
                    gnt_nxt      = '0;
                    busrq_n_nxt  = 1'b1;
                    last_gnt_nxt = winner;
                    revoked_nxt  = winner_oh;
                    mask_nxt     = (mask & bus.REQ) | winner_oh;
                    state_nxt    = RELEASE;
                end
`endif
            end
            RELEASE: begin
                busrq_n_nxt = 1'b1;
                gnt_nxt     = '0;
                if (bus.BUSAK_n) begin
                    gap_cnt_nxt = 8'(CPU_GAP);
                    state_nxt   = GAP;
                end
            end
            GAP: begin
                busrq_n_nxt = 1'b1;
                if (gap_cnt <= 8'd1) begin
                    gap_cnt_nxt = 8'd0;
                    state_nxt   = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 8'd1;
                end
            end
            default: begin
                gnt_nxt     = '0;
                busrq_n_nxt = 1'b1;
                state_nxt   = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset wins in any state.
    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            state    <= IDLE;
            gnt      <= '0;
            busrq_n  <= 1'b1;
            last_gnt <= IDX_W'(N_REQ - 1);
            winner   <= '0;
            gap_cnt  <= '0;
`ifdef Z80_BUS_ARB_TIMEOUT_EN
            hold_cnt <= '0;
            mask     <= '0;
            revoked  <= '0;
`endif
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            busrq_n  <= busrq_n_nxt;
            last_gnt <= last_gnt_nxt;
            winner   <= winner_nxt;
            gap_cnt  <= gap_cnt_nxt;
`ifdef Z80_BUS_ARB_TIMEOUT_EN
            hold_cnt <= hold_cnt_nxt;
            mask     <= mask_nxt;
            revoked  <= revoked_nxt;
`endif
        end
    end

    assign bus.GNT       = gnt;
    assign bus.BUSRQ_n   = busrq_n;
    assign bus.BUS_OWNED = |gnt;
`ifdef Z80_BUS_ARB_TIMEOUT_EN
    assign bus.REVOKED   = revoked;
`else
    assign bus.REVOKED   = '0;
`endif
endmodule

// File: tb/tb_z80_bus_arbiter.sv
// tb_z80_bus_arbiter: directed bench for z80_bus_arbiter with N_REQ=2,
// CPU_GAP=4, HOLD_MAX=8. The bench plays both the bus masters and the
// T80 core's BUSAK_n response. The timeout scenario is included only when
// Z80_BUS_ARB_TIMEOUT_EN is defined.
module tb_z80_bus_arbiter;
    localparam int CPU_GAP = 4;

    logic CLK_n;
    logic RESET;
    int   vectors;
    int   miscompares;

    z80_bus_arbiter_if #(.N_REQ(2)) bus ();

    z80_bus_arbiter #(
        .N_REQ    (2),
        .CPU_GAP  (CPU_GAP),
        .HOLD_MAX (8)
    ) dut (
        .CLK_n (CLK_n),
        .RESET (RESET),
        .bus   (bus.master)
    );

    // Free-running system clock.
    initial CLK_n = 1'b0;
    always #5 CLK_n = ~CLK_n;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge CLK_n);
        #1;
    endtask

    // Step until BUSRQ_n falls, bounded to 40 cycles; returns cycles taken.
    task automatic wait_busrq(output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (bus.BUSRQ_n === 1'b1 && n < 40);
    endtask

    // Reset values of every output.
    task automatic test_reset();
        RESET       = 1'b1;
        bus.REQ     = 2'b00;
        bus.BUSAK_n = 1'b1;
        tick(2);
        vectors++;
        if (bus.GNT !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_gnt: got %b, expected 00", bus.GNT);
        end
        vectors++;
        if (bus.BUSRQ_n !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_busrq: got %b, expected 1", bus.BUSRQ_n);
        end
        vectors++;
        if (bus.BUS_OWNED !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_owned: got %b, expected 0", bus.BUS_OWNED);
        end
        vectors++;
        if (bus.REVOKED !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_revoked: got %b, expected 00", bus.REVOKED);
        end
        RESET = 1'b0;
        tick(1);
        vectors++;
        if (bus.BUSRQ_n !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL idle_no_req_busrq: got %b, expected 1", bus.BUSRQ_n);
        end
    endtask

    // Both requesters held; each grant lasts 5 cycles; order 01,10,01,10.
    task automatic test_round_robin();
        logic [1:0] exp_tbl [4];
        int         n;
        exp_tbl = '{2'b01, 2'b10, 2'b01, 2'b10};
        bus.REQ = 2'b11;
        tick(1);
        vectors++;
        if (bus.BUSRQ_n !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rr_first_busrq: got %b, expected 0", bus.BUSRQ_n);
        end
        for (int g = 0; g < 4; g++) begin
            bus.BUSAK_n = 1'b0;
            tick(1);
            vectors++;
            if (bus.GNT !== exp_tbl[g] || bus.BUS_OWNED !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL rr_grant%0d: got GNT=%b OWNED=%b, expected GNT=%b OWNED=1",
                         g, bus.GNT, bus.BUS_OWNED, exp_tbl[g]);
            end
            tick(4);
            vectors++;
            if (bus.GNT !== exp_tbl[g]) begin
                miscompares++;
                $display("[TB] FAIL rr_hold%0d: got %b, expected %b", g, bus.GNT, exp_tbl[g]);
            end
            bus.REQ = bus.REQ & ~exp_tbl[g];
            tick(1);
            vectors++;
            if (bus.GNT !== 2'b00 || bus.BUSRQ_n !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL rr_release%0d: got GNT=%b BUSRQ_n=%b, expected GNT=00 BUSRQ_n=1",
                         g, bus.GNT, bus.BUSRQ_n);
            end
            bus.BUSAK_n = 1'b1;
            if (g < 3) begin
                bus.REQ = 2'b11;
                // 1 RELEASE edge + CPU_GAP GAP edges + 1 IDLE edge
                wait_busrq(n);
                vectors++;
                if (n !== CPU_GAP + 2) begin
                    miscompares++;
                    $display("[TB] FAIL rr_cpu_window%0d: got %0d cycles, expected %0d",
                             g, n, CPU_GAP + 2);
                end
            end else begin
                bus.REQ = 2'b00;
                tick(CPU_GAP + 1);
            end
        end
    endtask

    // One requester, core acknowledges 3 cycles after BUSRQ_n falls.
    task automatic test_single();
        bus.REQ = 2'b01;
        tick(1);
        vectors++;
        if (bus.BUSRQ_n !== 1'b0 || bus.GNT !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL single_busrq: got BUSRQ_n=%b GNT=%b, expected 0/00",
                     bus.BUSRQ_n, bus.GNT);
        end
        tick(2);
        vectors++;
        if (bus.GNT !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL single_no_early_gnt: got %b, expected 00", bus.GNT);
        end
        bus.BUSAK_n = 1'b0;
        tick(1);
        vectors++;
        if (bus.GNT !== 2'b01 || bus.BUS_OWNED !== 1'b1 || bus.REVOKED !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL single_gnt: got GNT=%b OWNED=%b REVOKED=%b, expected 01/1/00",
                     bus.GNT, bus.BUS_OWNED, bus.REVOKED);
        end
        tick(2);
        bus.REQ = 2'b00;
        tick(1);
        vectors++;
        if (bus.GNT !== 2'b00 || bus.BUSRQ_n !== 1'b1 || bus.BUS_OWNED !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_release: got GNT=%b BUSRQ_n=%b OWNED=%b, expected 00/1/0",
                     bus.GNT, bus.BUSRQ_n, bus.BUS_OWNED);
        end
        bus.BUSAK_n = 1'b1;
        tick(CPU_GAP + 1);
    endtask

    // Request withdrawn before the core acknowledges.
    task automatic test_aborted_acquire();
        int n;
        bus.REQ = 2'b01;
        tick(1);
        vectors++;
        if (bus.BUSRQ_n !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_busrq: got %b, expected 0", bus.BUSRQ_n);
        end
        tick(1);
        bus.REQ = 2'b00;
        tick(1);
        vectors++;
        if (bus.BUSRQ_n !== 1'b1 || bus.GNT !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL abort_release: got BUSRQ_n=%b GNT=%b, expected 1/00",
                     bus.BUSRQ_n, bus.GNT);
        end
        tick(1);
        bus.REQ = 2'b01;
        // now in GAP: CPU_GAP edges then 1 IDLE edge
        wait_busrq(n);
        vectors++;
        if (n !== CPU_GAP + 1) begin
            miscompares++;
            $display("[TB] FAIL abort_gap: got %0d cycles, expected %0d", n, CPU_GAP + 1);
        end
        bus.REQ = 2'b00;
        tick(CPU_GAP + 2);
    endtask

    // Core raises BUSAK_n while a grant is active.
    task automatic test_core_violation();
        int n;
        bus.REQ = 2'b01;
        tick(1);
        bus.BUSAK_n = 1'b0;
        tick(1);
        vectors++;
        if (bus.GNT !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL viol_gnt: got %b, expected 01", bus.GNT);
        end
        tick(1);
        bus.BUSAK_n = 1'b1;
        tick(1);
        vectors++;
        if (bus.GNT !== 2'b00 || bus.BUSRQ_n !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL viol_clear: got GNT=%b BUSRQ_n=%b, expected 00/1",
                     bus.GNT, bus.BUSRQ_n);
        end
        wait_busrq(n);
        vectors++;
        if (n !== CPU_GAP + 2) begin
            miscompares++;
            $display("[TB] FAIL viol_gap: got %0d cycles, expected %0d", n, CPU_GAP + 2);
        end
        bus.REQ = 2'b00;
        tick(CPU_GAP + 2);
    endtask

    // Reset asserted mid-grant, then both requesters: requester 0 first.
    task automatic test_reset_mid_grant();
        bus.REQ = 2'b10;
        tick(1);
        bus.BUSAK_n = 1'b0;
        tick(1);
        vectors++;
        if (bus.GNT !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL rstg_gnt: got %b, expected 10", bus.GNT);
        end
        RESET = 1'b1;
        tick(1);
        vectors++;
        if (bus.GNT !== 2'b00 || bus.BUSRQ_n !== 1'b1 || bus.BUS_OWNED !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rstg_outputs: got GNT=%b BUSRQ_n=%b OWNED=%b, expected 00/1/0",
                     bus.GNT, bus.BUSRQ_n, bus.BUS_OWNED);
        end
        RESET       = 1'b0;
        bus.BUSAK_n = 1'b1;
        bus.REQ     = 2'b11;
        tick(1);
        vectors++;
        if (bus.BUSRQ_n !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rstg_busrq: got %b, expected 0", bus.BUSRQ_n);
        end
        bus.BUSAK_n = 1'b0;
        tick(1);
        vectors++;
        if (bus.GNT !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL rstg_first_winner: got %b, expected 01", bus.GNT);
        end
        bus.REQ = 2'b00;
        tick(1);
        vectors++;
        if (bus.GNT !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL rstg_release: got %b, expected 00", bus.GNT);
        end
        bus.BUSAK_n = 1'b1;
        tick(CPU_GAP + 1);
    endtask

`ifdef Z80_BUS_ARB_TIMEOUT_EN
    // Requester 0 never lets go: revoked after 8 cycles and masked.
    task automatic test_timeout();
        bus.REQ = 2'b01;
        tick(1);
        bus.BUSAK_n = 1'b0;
        tick(1);
        tick(7);
        vectors++;
        if (bus.GNT !== 2'b01 || bus.REVOKED !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL to_hold: got GNT=%b REVOKED=%b, expected 01/00",
                     bus.GNT, bus.REVOKED);
        end
        tick(1);
        vectors++;
        if (bus.GNT !== 2'b00 || bus.REVOKED !== 2'b01 || bus.BUSRQ_n !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL to_revoke: got GNT=%b REVOKED=%b BUSRQ_n=%b, expected 00/01/1",
                     bus.GNT, bus.REVOKED, bus.BUSRQ_n);
        end
        bus.BUSAK_n = 1'b1;
        tick(1);
        vectors++;
        if (bus.REVOKED !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL to_pulse_width: got %b, expected 00", bus.REVOKED);
        end
        tick(CPU_GAP + 3);
        vectors++;
        if (bus.BUSRQ_n !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL to_masked: got %b, expected 1", bus.BUSRQ_n);
        end
        bus.REQ = 2'b11;
        tick(1);
        bus.BUSAK_n = 1'b0;
        tick(1);
        vectors++;
        if (bus.GNT !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL to_other_served: got %b, expected 10", bus.GNT);
        end
        bus.REQ = 2'b01;
        tick(1);
        bus.BUSAK_n = 1'b1;
        tick(CPU_GAP + 3);
        vectors++;
        if (bus.BUSRQ_n !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL to_still_masked: got %b, expected 1", bus.BUSRQ_n);
        end
        bus.REQ = 2'b00;
        tick(1);
        bus.REQ = 2'b01;
        tick(1);
        vectors++;
        if (bus.BUSRQ_n !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL to_unmasked: got %b, expected 0", bus.BUSRQ_n);
        end
        bus.BUSAK_n = 1'b0;
        tick(1);
        vectors++;
        if (bus.GNT !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL to_regrant: got %b, expected 01", bus.GNT);
        end
        bus.REQ = 2'b00;
        tick(1);
        bus.BUSAK_n = 1'b1;
        tick(CPU_GAP + 1);
    endtask
`endif

    // Scenario sequence and summary.
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_round_robin();
        test_single();
        test_aborted_acquire();
        test_core_violation();
        test_reset_mid_grant();
`ifdef Z80_BUS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
